// File: rtl/max_subtract.sv
// Subtracts a per-element selected max from each element with saturation; 2-cycle latency.
// No backpressure: i_en=0 freezes every register; i_valid bubbles abort the group counter.
module max_subtract #(
  parameter int N_ELEM = 64,
  parameter int DW     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [DW-1:0]        i_global_max,
  input  logic [3:0]           i_length_mode,
  input  logic [N_ELEM*DW-1:0] i_in_flat,
  input  logic [DW-1:0]        i_max64_0,
  input  logic [DW-1:0]        i_max32_0,
  input  logic [DW-1:0]        i_max32_1,
  input  logic [DW-1:0]        i_max16_0,
  input  logic [DW-1:0]        i_max16_1,
  input  logic [DW-1:0]        i_max16_2,
  input  logic [DW-1:0]        i_max16_3,
  output logic                 o_valid,
  output logic [N_ELEM*DW-1:0] o_diff_flat,
  output logic [3:0]           o_length_mode_byp,
  output logic [3:0]           o_vec_idx,
  output logic                 o_last,
  output logic                 o_err
);

  localparam int FW = N_ELEM * DW;

  logic [DW-1:0]     max16 [4];
  logic [DW-1:0]     max32 [2];
  logic [DW-1:0]     sel_max [N_ELEM];
  logic [DW-1:0]     s1_max [N_ELEM];
  logic [FW-1:0]     s1_x;
  logic [3:0]        s1_mode;
  logic              s1_valid;
  logic [FW-1:0]     diff_nxt;
  logic [N_ELEM-1:0] pos;

  logic [3:0] cnt;
  logic [3:0] grp_mode;
  logic       grouped;
  logic [3:0] glast;
  logic [3:0] idx_cur;
  logic [3:0] idx_nxt;
  logic [3:0] cnt_nxt;
  logic       last_nxt;

  assign max16[0] = i_max16_0;
  assign max16[1] = i_max16_1;
  assign max16[2] = i_max16_2;
  assign max16[3] = i_max16_3;
  assign max32[0] = i_max32_0;
  assign max32[1] = i_max32_1;

  genvar k;
  generate
    for (k = 0; k < N_ELEM; k++) begin : g_elem
      logic signed [DW:0] d;

      assign sel_max[k] = (i_length_mode == 4'd0) ? max16[(k/16)%4] :
                          (i_length_mode == 4'd1) ? max32[(k/32)%2] :
                          (i_length_mode == 4'd2) ? i_max64_0 : i_global_max;

      // Sign-extended difference: bits [DW:DW-1] == 2'b10 means below the most negative value
      assign d = $signed({s1_x[k*DW+DW-1], s1_x[k*DW +: DW]}) -
                 $signed({s1_max[k][DW-1], s1_max[k]});
      assign pos[k] = ~d[DW] & (|d[DW-1:0]);
      assign diff_nxt[k*DW +: DW] = (d[DW] & ~d[DW-1]) ? {1'b1, {(DW-1){1'b0}}} :
                                    pos[k]             ? '0 : d[DW-1:0];
    end
  endgenerate

  // Group of G = mode-1 vectors; a mode change restarts indexing at 0
  always_comb begin
    grouped  = (s1_mode >= 4'd3) && (s1_mode <= 4'd13);
    glast    = s1_mode - 4'd2;
    idx_cur  = (grp_mode == s1_mode) ? cnt : 4'd0;
    idx_nxt  = 4'd0;
    last_nxt = 1'b0;
    cnt_nxt  = 4'd0;
    if (s1_valid) begin
      if (grouped) begin
        idx_nxt  = idx_cur;
        last_nxt = (idx_cur == glast);
        cnt_nxt  = last_nxt ? 4'd0 : idx_cur + 4'd1;
      end else begin
        last_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_x              <= '0;
      s1_mode           <= '0;
      s1_valid          <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) s1_max[i] <= '0;
      o_valid           <= 1'b0;
      o_diff_flat       <= '0;
      o_length_mode_byp <= '0;
      o_vec_idx         <= '0;
      o_last            <= 1'b0;
      o_err             <= 1'b0;
      cnt               <= '0;
      grp_mode          <= '0;
    end else if (i_en) begin
      s1_x              <= i_in_flat;
      s1_mode           <= i_length_mode;
      s1_valid          <= i_valid;
      for (int i = 0; i < N_ELEM; i++) s1_max[i] <= sel_max[i];
      o_valid           <= s1_valid;
      o_diff_flat       <= diff_nxt;
      o_length_mode_byp <= s1_mode;
      o_vec_idx         <= idx_nxt;
      o_last            <= last_nxt;
      cnt               <= cnt_nxt;
      grp_mode          <= s1_mode;
      if (s1_valid && (|pos)) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_max_subtract.sv
// Directed + random bench for max_subtract with an expected-result queue.
module tb_max_subtract;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int FW = N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          valid = 1'b0;
  logic [15:0]   gmax = '0;
  logic [3:0]    mode = '0;
  logic [FW-1:0] data = '0;
  logic [15:0]   m64 = '0, m32_0 = '0, m32_1 = '0;
  logic [15:0]   m16_0 = '0, m16_1 = '0, m16_2 = '0, m16_3 = '0;

  logic          o_valid;
  logic [FW-1:0] o_diff_flat;
  logic [3:0]    o_length_mode_byp;
  logic [3:0]    o_vec_idx;
  logic          o_last;
  logic          o_err;

  max_subtract #(.N_ELEM(N), .DW(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid),
    .i_global_max(gmax), .i_length_mode(mode), .i_in_flat(data),
    .i_max64_0(m64), .i_max32_0(m32_0), .i_max32_1(m32_1),
    .i_max16_0(m16_0), .i_max16_1(m16_1), .i_max16_2(m16_2), .i_max16_3(m16_3),
    .o_valid(o_valid), .o_diff_flat(o_diff_flat), .o_length_mode_byp(o_length_mode_byp),
    .o_vec_idx(o_vec_idx), .o_last(o_last), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] diff;
    logic [3:0]    mode;
    logic [3:0]    idx;
    logic          last;
    logic          err;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  exp_t       held;
  logic [1:0] vpipe = '0;
  logic       exp_err = 1'b0;
  logic [3:0] m_cnt = '0;
  logic [3:0] m_mode = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    int bad = 0;
    for (int k = N - 1; k >= 0; k--)
      if (obs[16*k +: 16] !== exp[16*k +: 16]) bad = k;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: element %0d observed %h expected %h", tag, bad, obs[16*bad +: 16], exp[16*bad +: 16]);
    end
  endtask

  function automatic logic [15:0] sel(input int k, input logic [3:0] md);
    case (md)
      4'd0: begin
        case (k / 16)
          0: return m16_0;
          1: return m16_1;
          2: return m16_2;
          default: return m16_3;
        endcase
      end
      4'd1: return (k < 32) ? m32_0 : m32_1;
      4'd2: return m64;
      default: return gmax;
    endcase
  endfunction

  task automatic push();
    exp_t e;
    int   d;
    logic [3:0] icur;
    e.err = 1'b0;
    e.diff = '0;
    for (int k = 0; k < N; k++) begin
      d = int'($signed(data[16*k +: 16])) - int'($signed(sel(k, mode)));
      if (d < -32768) e.diff[16*k +: 16] = 16'h8000;
      else if (d > 0) begin
        e.diff[16*k +: 16] = 16'h0000;
        e.err = 1'b1;
      end else e.diff[16*k +: 16] = d[15:0];
    end
    e.mode = mode;
    if (mode >= 4'd3 && mode <= 4'd13) begin
      icur   = (m_mode == mode) ? m_cnt : 4'd0;
      e.idx  = icur;
      e.last = (int'(icur) == int'(mode) - 2);
      m_cnt  = e.last ? 4'd0 : icur + 4'd1;
    end else begin
      e.idx  = 4'd0;
      e.last = 1'b1;
      m_cnt  = 4'd0;
    end
    m_mode = mode;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic e_n);
    @(negedge clk);
    valid = v;
    en    = e_n;
    if (e_n) begin
      if (v) push();
      else m_cnt = 4'd0;
      vpipe = {vpipe[0], v};
    end
    @(posedge clk);
    #1;
    chk("valid", o_valid, vpipe[1]);
    if (e_n && vpipe[1]) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        held = sb.pop_front();
        exp_err = exp_err | held.err;
      end
    end
    if (vpipe[1]) begin
      chk_vec("diff", o_diff_flat, held.diff);
      chk("mode_byp", o_length_mode_byp, held.mode);
      chk("vec_idx", o_vec_idx, held.idx);
      chk("last", o_last, held.last);
    end else begin
      chk("last_idle", o_last, 0);
    end
    chk("err", o_err, exp_err);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk_vec({tag, "_diff"}, o_diff_flat, '0);
    chk({tag, "_mode"}, o_length_mode_byp, 0);
    chk({tag, "_idx"}, o_vec_idx, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    sb.delete();
    vpipe   = '0;
    exp_err = 1'b0;
    m_cnt   = '0;
    m_mode  = '0;
    valid   = 1'b0;
    en      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int k = 0; k < N; k++) data[16*k +: 16] = v;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset_held");
    rst_n = 1'b1;
    step(0, 1);
    step(0, 1);

    // Mode 13: one full 12-vector group
    mode = 4'd13; gmax = 16'h03E7; fill(16'h0064);
    m64 = 16'h0001; m32_0 = 16'h0002; m16_0 = 16'h0003;
    repeat (12) step(1, 1);
    step(0, 1); step(0, 1);

    // Mode 0: per-16 segment maxes
    mode = 4'd0; m16_0 = 16'd10; m16_1 = 16'd20; m16_2 = 16'd30; m16_3 = 16'd40;
    gmax = 16'h1234; fill(16'd5);
    step(1, 1); step(1, 1);
    step(0, 1); step(0, 1);

    // Mode 2: saturation at both ends
    mode = 4'd2; m64 = 16'h7FFF; m32_0 = 16'd100; m32_1 = 16'd200; fill(16'h0000);
    data[15:0] = 16'h8000; data[31:16] = 16'h7FFF; data[1023:1008] = 16'h0001;
    step(1, 1);
    step(0, 1); step(0, 1);

    // Short groups and mid-group mode change
    mode = 4'd3; gmax = 16'h0100; fill(16'h0010);
    step(1, 1); step(1, 1); step(1, 1);
    mode = 4'd5; step(1, 1);
    mode = 4'd6; step(1, 1); step(1, 1);
    step(0, 1); step(0, 1);

    // Mode 5 with a 3-cycle stall, then a bubble
    mode = 4'd5; fill(16'h0020);
    step(1, 1);
    step(1, 0); step(1, 0); step(1, 0);
    step(1, 1);
    step(0, 1);
    step(1, 1);
    step(0, 1); step(0, 1);

    // Over-max elements in invalid cycles leave the error flag alone
    mode = 4'd2; m64 = 16'h0000; fill(16'h0005);
    step(0, 1); step(0, 1); step(0, 1);

    // Mode 1: one element above its max, then clean vectors
    mode = 4'd1; m32_0 = 16'h0000; m32_1 = 16'h0010; fill(16'h0000);
    data[63:48] = 16'd5;
    step(1, 1);
    fill(16'h0000);
    step(1, 1); step(1, 1);
    step(0, 1); step(0, 1);

    // Random traffic
    repeat (40) begin
      mode = 4'($urandom_range(0, 15));
      gmax = 16'($urandom); m64 = 16'($urandom);
      m32_0 = 16'($urandom); m32_1 = 16'($urandom);
      m16_0 = 16'($urandom); m16_1 = 16'($urandom);
      m16_2 = 16'($urandom); m16_3 = 16'($urandom);
      for (int k = 0; k < N; k++) data[16*k +: 16] = 16'($urandom);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    step(0, 1); step(0, 1);

    // Asynchronous reset mid-group, then a fresh group
    mode = 4'd4; gmax = 16'h0000; fill(16'hFFF0);
    step(1, 1); step(1, 1);
    do_reset();
    step(1, 1); step(1, 1); step(1, 1); step(1, 1);
    step(0, 1); step(0, 1);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
